// File: rtl/keypad_lock_ctrl.sv
// Keypad passcode controller: buffers decoded keys, checks them against a stored
// code, and sequences unlock, denial, lockout and code programming.
module keypad_lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h0965,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    UNLOCK_CYCLES  = 1000,
  parameter int                    LOCKOUT_CYCLES = 5000,
  parameter int                    ENTRY_TIMEOUT  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       scan_en,
  output logic       unlocked,
  output logic       granted,
  output logic       denied,
  output logic       locked_out,
  output logic       prog_done,
  output logic [2:0] digit_count,
  output logic [2:0] fail_count
);
  localparam int MAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC = (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
  localparam int TW = $clog2(MAX_CYC) + 1;
  // Loads are N-1 so the expiry edge lands exactly N edges after the load edge.
  localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    LEN      = 3'(CODE_LEN);
  localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAILS);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_LOCKOUT, S_PROGRAM} state_t;
  typedef logic [CODE_LEN-1:0][3:0] code_t;

  state_t         state_q, state_d;
  code_t          buf_q, buf_d, buf_wr, code_q, code_d;
  logic [2:0]     cnt_q, cnt_d, fail_q, fail_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           scan_en_q, scan_en_d, unlocked_q, unlocked_d, locked_out_q, locked_out_d;
  logic           granted_q, granted_d, denied_q, denied_d, prog_done_q, prog_done_d;
  logic           is_digit, is_star, is_hash, is_prog, tmr_zero;

  always_comb begin
    is_digit = 1'b0;
    case (key_code)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1101: is_digit = key_valid;
      default: is_digit = 1'b0;
    endcase
  end

  assign is_star  = key_valid & (key_code == 4'b1100);
  assign is_hash  = key_valid & (key_code == 4'b1110);
  assign is_prog  = key_valid & (key_code == 4'b0011);
  assign tmr_zero = (tmr_q == '0);

  // Digit k of the entry lives in the same nibble as digit k of the code (digit 0 = MSBs).
  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < CODE_LEN; i++)
      if (cnt_q == 3'(i)) buf_wr[CODE_LEN-1-i] = key_code;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    tmr_d       = tmr_q;
    granted_d   = 1'b0;
    denied_d    = 1'b0;
    prog_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (is_digit) begin
          buf_d           = '0;
          buf_d[CODE_LEN-1] = key_code;
          cnt_d           = 3'd1;
          tmr_d           = T_ENTRY;
          state_d         = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (is_digit) begin
          buf_d = buf_wr;
          cnt_d = cnt_q + 3'd1;
          tmr_d = T_ENTRY;
          if (cnt_q == LEN - 3'd1) state_d = S_CHECK;
        end else if (is_star || tmr_zero) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          granted_d = 1'b1;
          fail_d    = '0;
          tmr_d     = T_UNLOCK;
          state_d   = S_UNLOCKED;
        end else if (({1'b0, fail_q} + 4'd1) < FAIL_LIM) begin
          denied_d = 1'b1;
          fail_d   = fail_q + 3'd1;
          tmr_d    = '0;
          state_d  = S_IDLE;
        end else begin
          denied_d = 1'b1;
          tmr_d    = T_LOCK;
          state_d  = S_LOCKOUT;
        end
      end
      S_UNLOCKED: begin
        if (tmr_zero || is_hash) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else if (is_prog) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = T_ENTRY;
          state_d = S_PROGRAM;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_PROGRAM: begin
        if (is_digit && (cnt_q < LEN)) begin
          buf_d = buf_wr;
          cnt_d = cnt_q + 3'd1;
          tmr_d = T_ENTRY;
        end else if (is_hash && (cnt_q == LEN)) begin
          code_d      = buf_q;
          prog_done_d = 1'b1;
          buf_d       = '0;
          cnt_d       = '0;
          tmr_d       = '0;
          state_d     = S_IDLE;
        end else if (is_star || tmr_zero) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (tmr_zero) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    scan_en_d    = (state_d != S_LOCKOUT);
    unlocked_d   = (state_d == S_UNLOCKED);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      code_q       <= DEFAULT_CODE;
      cnt_q        <= '0;
      fail_q       <= '0;
      tmr_q        <= '0;
      scan_en_q    <= 1'b1;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      granted_q    <= 1'b0;
      denied_q     <= 1'b0;
      prog_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      tmr_q        <= tmr_d;
      scan_en_q    <= scan_en_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      granted_q    <= granted_d;
      denied_q     <= denied_d;
      prog_done_q  <= prog_done_d;
    end
  end

  assign scan_en     = scan_en_q;
  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign granted     = granted_q;
  assign denied      = denied_q;
  assign prog_done   = prog_done_q;
  assign digit_count = cnt_q;
  assign fail_count  = fail_q;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios with literal expectations plus
// random key traffic, all checked every cycle against an event-time reference model.
module tb_keypad_lock_ctrl;
  localparam int          CODE_LEN  = 4;
  localparam logic [15:0] DEF_CODE  = 16'h0965;
  localparam int          MAX_FAILS = 3;
  localparam int          UNL       = 1000;
  localparam int          LCK       = 5000;
  localparam int          TMO       = 2000;
  localparam int K_STAR = 12, K_HASH = 14, K_A = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNL = 3, M_LCK = 4, M_PROG = 5;

  logic       clk = 1'b0, rst = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       scan_en, unlocked, granted, denied, locked_out, prog_done;
  logic [2:0] digit_count, fail_count;

  keypad_lock_ctrl #(
    .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF_CODE), .MAX_FAILS(MAX_FAILS),
    .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK), .ENTRY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .scan_en(scan_en), .unlocked(unlocked), .granted(granted), .denied(denied),
    .locked_out(locked_out), .prog_done(prog_done),
    .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: entry kept as a queue of key codes, timing as absolute edge numbers.
  int mode, fails, cyc, last_key, t_enter, tcyc;
  int digits[$];
  int code[CODE_LEN];
  bit e_gr, e_de, e_pd;
  int n_checks = 0, n_pass = 0;
  int enc[10] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10};

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
  endtask

  function automatic bit is_dig(int k);
    foreach (enc[i]) if (enc[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit code_match();
    if (digits.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++) if (digits[i] != code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; fails = 0; cyc = 0; last_key = 0; t_enter = 0;
    digits.delete();
    e_gr = 0; e_de = 0; e_pd = 0;
    for (int i = 0; i < CODE_LEN; i++) code[i] = int'((DEF_CODE >> (4 * (CODE_LEN - 1 - i))) & 16'hF);
  endtask

  task automatic model_step(bit kv, int k);
    cyc++;
    e_gr = 0; e_de = 0; e_pd = 0;
    case (mode)
      M_IDLE: if (kv && is_dig(k)) begin
        digits.delete(); digits.push_back(k); last_key = cyc; mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (kv && is_dig(k)) begin
          digits.push_back(k); last_key = cyc;
          if (digits.size() == CODE_LEN) mode = M_CHECK;
        end else if ((kv && k == K_STAR) || (cyc - last_key >= TMO)) begin
          digits.delete(); mode = M_IDLE;
        end
      end
      M_CHECK: begin
        if (code_match()) begin
          e_gr = 1; fails = 0; mode = M_UNL; t_enter = cyc;
        end else begin
          e_de = 1;
          if (fails + 1 < MAX_FAILS) begin fails++; mode = M_IDLE; end
          else begin mode = M_LCK; t_enter = cyc; end
        end
        digits.delete();
      end
      M_UNL: begin
        if ((cyc - t_enter >= UNL) || (kv && k == K_HASH)) mode = M_IDLE;
        else if (kv && k == K_A) begin mode = M_PROG; digits.delete(); last_key = cyc; end
      end
      M_PROG: begin
        if (kv && is_dig(k) && digits.size() < CODE_LEN) begin
          digits.push_back(k); last_key = cyc;
        end else if (kv && k == K_HASH && digits.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) code[i] = digits[i];
          e_pd = 1; digits.delete(); mode = M_IDLE;
        end else if ((kv && k == K_STAR) || (cyc - last_key >= TMO)) begin
          digits.delete(); mode = M_IDLE;
        end
      end
      M_LCK: if (cyc - t_enter >= LCK) begin fails = 0; mode = M_IDLE; end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    tcyc++;
    if (rst) model_reset();
    else model_step(key_valid, int'(key_code));
    #1;
  endtask

  task automatic press(int k);
    key_valid = 1'b1; key_code = 4'(k);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic press_d(int d); press(enc[d]); endtask
  task automatic idle(int n); repeat (n) tick(); endtask
  task automatic enter(int a, int b, int c, int d);
    press_d(a); press_d(b); press_d(c); press_d(d);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1; model_reset();
    #1;
  endtask

  always @(negedge clk) begin
    chk("scan_en",     int'(scan_en),     int'(mode != M_LCK));
    chk("unlocked",    int'(unlocked),    int'(mode == M_UNL));
    chk("locked_out",  int'(locked_out),  int'(mode == M_LCK));
    chk("granted",     int'(granted),     int'(e_gr));
    chk("denied",      int'(denied),      int'(e_de));
    chk("prog_done",   int'(prog_done),   int'(e_pd));
    chk("digit_count", int'(digit_count), digits.size());
    chk("fail_count",  int'(fail_count),  fails);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ep;
    tcyc = 0;
    model_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_scan_en", int'(scan_en), 1);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_digit_count", int'(digit_count), 0);

    // Correct default code, then full unlock hold
    enter(1, 8, 6, 5);
    chk("t1_dc_in_check", int'(digit_count), 4);
    chk("t1_granted_early", int'(granted), 0);
    tick();
    chk("t1_granted", int'(granted), 1);
    chk("t1_unlocked", int'(unlocked), 1);
    n = 0;
    while (unlocked && n < 3000) begin n++; tick(); end
    chk("t1_unlock_len", n, UNL);

    // Three wrong codes -> lockout, keys ignored throughout
    for (int r = 1; r <= 3; r++) begin
      enter(1, 2, 3, 4);
      tick();
      chk("t2_denied", int'(denied), 1);
      if (r < 3) chk("t2_fail_count", int'(fail_count), r);
    end
    chk("t2_locked_out", int'(locked_out), 1);
    chk("t2_scan_en", int'(scan_en), 0);
    n = 0;
    while (locked_out && n < 6000) begin
      n++;
      if (n % 97 == 0) press_d(1); else tick();
    end
    chk("t2_lock_len", n, LCK);
    chk("t2_fail_zero", int'(fail_count), 0);
    enter(1, 8, 6, 5); tick();
    chk("t2_grant_after", int'(granted), 1);
    press(K_HASH);
    chk("t2_relock", int'(unlocked), 0);

    // Clear mid-entry
    press_d(1); press_d(8);
    chk("t3_dc2", int'(digit_count), 2);
    press(K_STAR);
    chk("t3_dc_clear", int'(digit_count), 0);
    enter(1, 8, 6, 5); tick();
    chk("t3_granted", int'(granted), 1);
    press(K_HASH);

    // Entry timeout does not touch the fail count; key on the expiry edge continues
    enter(1, 2, 3, 4); tick();
    press_d(1); idle(TMO - 1);
    chk("t4_before_tmo", int'(digit_count), 1);
    tick();
    chk("t4_tmo_clear", int'(digit_count), 0);
    chk("t4_fail_kept", int'(fail_count), 1);
    press_d(1); idle(TMO - 1); press_d(8);
    chk("t4_expiry_key", int'(digit_count), 2);
    press_d(6); press_d(5); tick();
    chk("t4_granted", int'(granted), 1);

    // Programming a new code
    press(K_A);
    chk("t5_prog_unl", int'(unlocked), 0);
    enter(4, 3, 2, 1); press(K_HASH);
    chk("t5_prog_done", int'(prog_done), 1);
    tick();
    enter(1, 8, 6, 5); tick();
    chk("t5_old_denied", int'(denied), 1);
    enter(4, 3, 2, 1); tick();
    chk("t5_new_granted", int'(granted), 1);
    press(K_A); press_d(4); press_d(3); press(K_HASH);
    chk("t5_short_hash", int'(prog_done), 0);
    chk("t5_short_dc", int'(digit_count), 2);
    press(K_STAR);
    enter(4, 3, 2, 1); tick();
    chk("t5_code_kept", int'(granted), 1);
    press(K_HASH);

    // Async reset mid-entry and while unlocked
    press_d(1); press_d(8);
    async_reset();
    chk("t6_rst_dc", int'(digit_count), 0);
    chk("t6_rst_scan", int'(scan_en), 1);
    tick(); rst = 1'b0;
    enter(1, 8, 6, 5); tick();
    chk("t6_default_back", int'(granted), 1);
    press(K_A); enter(4, 3, 2, 1); press(K_HASH);
    enter(4, 3, 2, 1); tick(); idle(10);
    async_reset();
    chk("t6_rst_unlocked", int'(unlocked), 0);
    tick(); rst = 1'b0;
    enter(4, 3, 2, 1); tick();
    chk("t6_prog_lost", int'(denied), 1);
    enter(1, 8, 6, 5); tick();
    chk("t6_default_grant", int'(granted), 1);

    // Random traffic
    ep = 0;
    while (ep < 400 && tcyc < 85000) begin
      ep++;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: for (int i = 0; i < CODE_LEN; i++) begin press(code[i]); idle($urandom_range(0, 3)); end
        4, 5:       for (int i = 0; i < CODE_LEN; i++) begin press(enc[$urandom_range(0, 9)]); idle($urandom_range(0, 2)); end
        6:          repeat ($urandom_range(1, 6)) press($urandom_range(0, 15));
        7:          if ($urandom_range(0, 3) == 0) idle($urandom_range(TMO - 3, TMO + 2));
                    else idle($urandom_range(1, 40));
        8: begin
          press(K_A);
          repeat ($urandom_range(0, 6)) press(enc[$urandom_range(0, 9)]);
          press(K_HASH);
        end
        default:    press(K_HASH);
      endcase
      if ($urandom_range(0, 60) == 0) begin
        async_reset(); tick(); rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Sequencing controller for the 4x4 matrix keypad scanner. It gates the scanner, collects decoded key events into a passcode entry buffer, and compares the entry against a stored code. It drives unlock, denial, lockout and code-programming behaviour for the door lock. It sits between the keypad scan/decode datapath and the lock actuator and status LEDs.

## Interface
Parameters:
- CODE_LEN, 4: digits per passcode (2..7).
- DEFAULT_CODE, 16'h0965: reset code, 4 bits per digit, digit 0 in the MSBs. This is 1865 in matrix encoding.
- MAX_FAILS, 3: consecutive wrong entries that trigger lockout.
- UNLOCK_CYCLES, 1000: unlock hold time.
- LOCKOUT_CYCLES, 5000: lockout duration.
- ENTRY_TIMEOUT, 2000: idle cycles allowed between keys in ENTRY or PROGRAM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  one-cycle pulse; a decoded key is present.
- key_code  in  4  {row[1:0], col[1:0]}. Digits: 1=0000, 2=0001, 3=0010, 4=0100, 5=0101, 6=0110, 7=1000, 8=1001, 9=1010, 0=1101. Controls: *=1100 (clear), #=1110 (enter/relock), A=0011 (program). B, C, D are ignored.
- scan_en  out  1  enables the keypad scanner.
- unlocked  out  1  lock actuator drive.
- granted  out  1  one-cycle pulse on a correct code.
- denied  out  1  one-cycle pulse on a wrong code.
- locked_out  out  1  high during lockout.
- prog_done  out  1  one-cycle pulse when a new code is committed.
- digit_count  out  3  digits currently buffered.
- fail_count  out  3  consecutive failures.

## Operation
- States: IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT, PROGRAM.
- Reset values:
  - State is IDLE and the code register loads DEFAULT_CODE.
  - scan_en=1; all other outputs are 0; buffer and timers are cleared.
  - Reset mid-operation aborts everything, including a partial PROGRAM entry.
- IDLE:
  - A digit stores into buffer[0], sets digit_count=1 and moves to ENTRY.
  - All other keys are ignored.
- ENTRY:
  - A digit stores into buffer[digit_count] and increments digit_count.
  - The edge that stores digit CODE_LEN moves to CHECK.
  - * clears the buffer and returns to IDLE.
  - #, A, B, C, D are ignored and do not reload the timer.
  - Every accepted key reloads the timer.
  - Timeout clears the buffer, returns to IDLE, and does not count a fail.
- CHECK: lasts exactly one cycle; key_valid is ignored.
  - On a match: granted=1, fail_count=0, go to UNLOCKED.
  - On a mismatch with fail_count+1 < MAX_FAILS: denied=1, fail_count++, go to IDLE.
  - On a mismatch otherwise: denied=1, go to LOCKOUT.
  - The buffer and digit_count are cleared on exit.
- UNLOCKED:
  - unlocked=1 and scan_en=1.
  - Expiry after UNLOCK_CYCLES, or #, goes to IDLE.
  - A goes to PROGRAM with the buffer cleared.
  - Other keys are ignored.
- PROGRAM:
  - unlocked=0.
  - Digits are buffered up to CODE_LEN; extra digits are ignored.
  - # with digit_count==CODE_LEN commits the buffer to the code register, pulses prog_done, and goes to IDLE.
  - # with fewer digits is ignored.
  - * or timeout aborts to IDLE with the code unchanged.
- LOCKOUT:
  - locked_out=1 and scan_en=0; key_valid is ignored.
  - After LOCKOUT_CYCLES: fail_count=0 and go to IDLE.
- Timer:
  - Single down-counter, width $clog2 of the largest cycle parameter plus 1.
  - Loaded on entry to ENTRY, UNLOCKED, LOCKOUT and PROGRAM.
  - Expiry occurs when the count reaches 0.
- Comparison covers all CODE_LEN nibbles exactly.

## Timing
- All outputs are registered and change only on a clk rising edge; rst acts immediately.
- A key is accepted on the edge where key_valid=1.
  - digit_count updates on that same edge.
  - The last digit enters CHECK on that edge.
  - granted/denied assert on the next edge, so the pulse is high 2 edges after the last key_valid.
- unlocked rises on the same edge as granted and stays high exactly UNLOCK_CYCLES cycles.
- locked_out rises with the final denied pulse and stays high exactly LOCKOUT_CYCLES cycles.
- Simultaneous events:
  - Key and timeout in the same cycle in ENTRY or PROGRAM: the key wins and the timer reloads.
  - A and expiry in the same cycle in UNLOCKED: expiry wins.
  - # and expiry in the same cycle: go to IDLE, no difference.
- Back-to-back key_valid on consecutive cycles is legal; each one is processed.

## Test plan
- Reset then keys 1,8,6,5 (0000,1001,0110,0101):
  - granted pulses 2 edges after the last key.
  - unlocked is high for 1000 cycles, then the block returns to IDLE.
- Three wrong codes (1,2,3,4):
  - denied pulses three times and fail_count goes 1, 2.
  - On the third, locked_out=1, scan_en=0, and keys are ignored for 5000 cycles.
  - Then fail_count=0 and the correct code grants.
- Digits 1,8, then *:
  - digit_count becomes 0 and the state is IDLE.
  - Then 1,8,6,5 grants.
- Digit 1, then no keys for 2000 cycles:
  - The buffer is cleared and fail_count is unchanged.
  - Key pressed exactly on the expiry cycle: the entry continues.
- Unlock, then A, 4,3,2,1, #:
  - prog_done pulses.
  - 1,8,6,5 is now denied and 4,3,2,1 grants.
  - Variant: A, 4,3, # is ignored, then * keeps the old code.
- Reset asserted mid-entry and during UNLOCKED:
  - All outputs immediately return to their reset values.
  - The code reverts to DEFAULT_CODE.
